// File: rtl/conv_accumulator.sv
// Convolution accumulator: multiplies taps, sums per output element,
// then shifts, applies ReLU, saturates and writes to a sequential address.
module conv_accumulator #(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int ACC_W     = 20,
  parameter int SHIFT     = 0,
  parameter bit RELU      = 1'b0,
  parameter int OUT_DEPTH = 64,
  localparam int ADDR_W   = $clog2(OUT_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_sum,
  input  logic                en_save,
  input  logic                finish,
  input  logic signed [7:0]   in_row,
  input  logic signed [7:0]   in_col,
  input  logic signed [7:0]   pixel,
  input  logic signed [7:0]   weight,
  output logic signed [7:0]   out_data,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_we,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(OUT_DEPTH - 1);

  state_e state_q, state_d;
  logic drain_q, drain_d;
  logic v1_q, v1_d;
  logic s1_q, s1_d;
  logic signed [ACC_W-1:0] p1_q, p1_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [7:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, we_d;
  logic ovf_q, ovf_d;

  logic accept;
  logic pad;
  logic signed [15:0] prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] r;

  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (finish) state_d = DRAIN;
        else if (en_sum || en_save) state_d = RUN;
      end
      RUN: begin
        if (finish) state_d = DRAIN;
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = DONE;
          drain_d = 1'b0;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Taps are only taken while the iterator is still running.
  assign accept = (state_q == IDLE) || (state_q == RUN);

  assign pad = (int'(in_row) < 0) || (int'(in_row) >= IMG_H)
            || (int'(in_col) < 0) || (int'(in_col) >= IMG_W);

  assign prod = $signed({{8{pixel[7]}}, pixel})
              * $signed({{8{weight[7]}}, weight});

  always_comb begin
    v1_d = accept && en_sum;
    s1_d = accept && en_save;
    p1_d = '0;
    if (accept && !pad)
      p1_d = {{(ACC_W-16){prod[15]}}, prod};
  end

  assign sum = acc_q + (v1_q ? p1_q : '0);

  always_comb begin
    r = sum >>> SHIFT;
    if (RELU && r < 0) r = '0;
  end

  always_comb begin
    acc_d  = sum;
    data_d = data_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    ovf_d  = ovf_q;
    if (s1_q) begin
      acc_d = '0;
      we_d  = 1'b1;
      if (r > SAT_HI) data_d = 8'sd127;
      else if (r < SAT_LO) data_d = -8'sd128;
      else data_d = r[7:0];
    end
    // Address advances after the pulse so the write sees a stable address.
    if (we_q) begin
      if (addr_q == ADDR_LAST) begin
        addr_d = '0;
        ovf_d  = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      v1_q    <= 1'b0;
      s1_q    <= 1'b0;
      p1_q    <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      v1_q    <= v1_d;
      s1_q    <= s1_d;
      p1_q    <= p1_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data = data_q;
  assign out_addr = addr_q;
  assign out_we   = we_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator: four parameter variants
// share one stimulus stream; each check looks at the relevant instance.
module tb_conv_accumulator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_sum = 1'b0, en_save = 1'b0, finish = 1'b0;
  logic signed [7:0] in_row = '0, in_col = '0, pixel = '0, weight = '0;

  logic signed [7:0] d0, d1, d2, d3;
  logic [5:0] a0, a1, a2;
  logic [1:0] a3;
  logic we0, we1, we2, we3;
  logic b0, b1, b2, b3;
  logic dn0, dn1, dn2, dn3;
  logic ov0, ov1, ov2, ov3;

  logic signed [7:0] mem [4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  conv_accumulator u0 (
    .clk(clk), .reset(reset), .en_sum(en_sum), .en_save(en_save),
    .finish(finish), .in_row(in_row), .in_col(in_col),
    .pixel(pixel), .weight(weight), .out_data(d0), .out_addr(a0),
    .out_we(we0), .busy(b0), .done(dn0), .overflow(ov0));

  conv_accumulator #(.RELU(1'b1)) u_relu (
    .clk(clk), .reset(reset), .en_sum(en_sum), .en_save(en_save),
    .finish(finish), .in_row(in_row), .in_col(in_col),
    .pixel(pixel), .weight(weight), .out_data(d1), .out_addr(a1),
    .out_we(we1), .busy(b1), .done(dn1), .overflow(ov1));

  conv_accumulator #(.SHIFT(1)) u_sh (
    .clk(clk), .reset(reset), .en_sum(en_sum), .en_save(en_save),
    .finish(finish), .in_row(in_row), .in_col(in_col),
    .pixel(pixel), .weight(weight), .out_data(d2), .out_addr(a2),
    .out_we(we2), .busy(b2), .done(dn2), .overflow(ov2));

  conv_accumulator #(.OUT_DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .en_sum(en_sum), .en_save(en_save),
    .finish(finish), .in_row(in_row), .in_col(in_col),
    .pixel(pixel), .weight(weight), .out_data(d3), .out_addr(a3),
    .out_we(we3), .busy(b3), .done(dn3), .overflow(ov3));

  always @(posedge clk)
    if (we3) mem[a3] <= d3;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tap(input int r, input int c, input int p,
                     input int w, input bit sv, input bit fin);
    @(negedge clk);
    en_sum  = 1'b1;
    en_save = sv;
    finish  = fin;
    in_row  = 8'(r);
    in_col  = 8'(c);
    pixel   = 8'(p);
    weight  = 8'(w);
  endtask

  task automatic idle();
    @(negedge clk);
    en_sum  = 1'b0;
    en_save = 1'b0;
    finish  = 1'b0;
    in_row  = '0;
    in_col  = '0;
    pixel   = '0;
    weight  = '0;
  endtask

  task automatic win9(input int r0, input int c0, input int p,
                      input int w, input bit fin);
    for (int i = 0; i < 9; i++)
      tap(r0 + i / 3, c0 + i % 3, p, w, i == 8, fin && i == 8);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_data", d0, 0);
    chk("rst_addr", 32'(a0), 0);
    chk("rst_we", 32'(we0), 0);
    chk("rst_busy", 32'(b0), 0);
    chk("rst_done", 32'(dn0), 0);
    chk("rst_ovf", 32'(ov0), 0);
    reset = 1'b0;

    // 1: nine in-range taps of 2*1
    win9(1, 1, 2, 1, 1'b0);
    idle();
    chk("t1_lat", 32'(we0), 0);
    chk("t1_busy", 32'(b0), 1);
    idle();
    chk("t1_we", 32'(we0), 1);
    chk("t1_data", d0, 18);
    chk("t1_addr", 32'(a0), 0);
    idle();
    chk("t1_we_off", 32'(we0), 0);
    chk("t1_addr_inc", 32'(a0), 1);

    // 2: positive and negative saturation, ReLU
    win9(1, 1, 127, 127, 1'b0);
    idle();
    idle();
    chk("t2_pos_we", 32'(we0), 1);
    chk("t2_pos", d0, 127);
    chk("t2_pos_relu", d1, 127);
    win9(1, 1, 127, -127, 1'b0);
    idle();
    idle();
    chk("t2_neg", d0, -128);
    chk("t2_neg_relu", d1, 0);
    chk("t2_neg_sh", d2, -128);
    chk("t2_addr", 32'(a0), 2);

    // 3: window at the corner, padded taps contribute nothing
    win9(-1, -1, 1, 1, 1'b0);
    idle();
    idle();
    chk("t3_we", 32'(we0), 1);
    chk("t3_pad", d0, 4);
    chk("t3_shift", d2, 2);

    // 4: address wrap on a 4-deep buffer
    do_reset();
    chk("t4_rst_ovf", 32'(ov3), 0);
    for (int k = 1; k <= 5; k++) begin
      tap(0, 0, k, 1, 1'b1, 1'b0);
      idle();
      idle();
      chk("t4_we", 32'(we3), 1);
      chk("t4_data", d3, k);
      chk("t4_addr", 32'(a3), (k - 1) % 4);
      chk("t4_ovf", 32'(ov3), (k == 5) ? 1 : 0);
    end
    idle();
    chk("t4_ovf_sticky", 32'(ov3), 1);
    chk("t4_slot0", mem[0], 5);

    // 5: reset mid-element discards the partial sum
    do_reset();
    for (int i = 0; i < 4; i++) tap(1, 1, 5, 5, 1'b0, 1'b0);
    do_reset();
    chk("t5_rst_we", 32'(we0), 0);
    chk("t5_rst_addr", 32'(a0), 0);
    chk("t5_rst_busy", 32'(b0), 0);
    win9(2, 2, 1, 3, 1'b0);
    idle();
    idle();
    chk("t5_we", 32'(we0), 1);
    chk("t5_data", d0, 27);
    chk("t5_addr", 32'(a0), 0);

    // 6: finish with the last save, drain, then done
    win9(0, 0, 1, 1, 1'b1);
    idle();
    chk("t6_drain1_busy", 32'(b0), 1);
    chk("t6_drain1_done", 32'(dn0), 0);
    chk("t6_drain1_we", 32'(we0), 0);
    idle();
    chk("t6_drain2_busy", 32'(b0), 1);
    chk("t6_drain2_we", 32'(we0), 1);
    chk("t6_data", d0, 9);
    chk("t6_addr", 32'(a0), 1);
    chk("t6_drain2_done", 32'(dn0), 0);
    idle();
    chk("t6_done", 32'(dn0), 1);
    chk("t6_busy_off", 32'(b0), 0);
    chk("t6_we_off", 32'(we0), 0);
    tap(1, 1, 3, 3, 1'b1, 1'b0);
    idle();
    idle();
    chk("t6_ignored_we", 32'(we0), 0);
    idle();
    chk("t6_ignored_we2", 32'(we0), 0);
    chk("t6_done_hold", 32'(dn0), 1);
    chk("t6_addr_hold", 32'(a0), 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
